// File: rtl/sdp_arb_ctrl.sv
// Round-robin arbiter sharing one fixed-latency datapath between two requesters.
// Tracks issued requester IDs in a tag pipe and supports a flush/drain handshake.
module sdp_arb_ctrl #(
    parameter int unsigned W   = 8,
    parameter int unsigned LAT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_ctl,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_ctl,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,
    output logic         dp_ctl_a,
    output logic         dp_ctl_b,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    output logic [W-1:0] dp_c,
    input  logic [W-1:0] dp_out,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp_data,
    input  logic         flush,
    output logic         flush_done,
    output logic         busy
);
    localparam int unsigned CW = $clog2(LAT + 2);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e        state_q;
    logic          rr_last_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic [LAT:0]  tag_vld_q;
    logic [LAT:0]  tag_id_q;

    logic can_grant;
    logic gnt0;
    logic gnt1;
    logic xfer;
    logic rsp_vld;

    // Ready is also held low while reset is asserted so every output reads 0.
    assign can_grant  = reset && (state_q != StDrain) && !flush;
    assign gnt0       = can_grant && req0_valid && (!req1_valid || rr_last_q);
    assign gnt1       = can_grant && req1_valid && (!req0_valid || !rr_last_q);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 || gnt1;

    assign rsp_vld    = tag_vld_q[LAT];
    assign rsp0_valid = rsp_vld && !tag_id_q[LAT];
    assign rsp1_valid = rsp_vld && tag_id_q[LAT];
    assign rsp_data   = rsp_vld ? dp_out : '0;
    assign busy       = (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (xfer && !rsp_vld) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!xfer && rsp_vld) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q  <= 1'b1;
            inflight_q <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
        end else begin
            if (xfer) begin
                rr_last_q <= gnt1;
            end
            inflight_q <= inflight_d;
            tag_vld_q  <= {tag_vld_q[LAT-1:0], xfer};
            tag_id_q   <= {tag_id_q[LAT-1:0], gnt1};
        end
    end

    // Idle cycles present a zero bubble on the datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_ctl_a <= 1'b0;
            dp_ctl_b <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_c     <= '0;
        end else if (xfer) begin
            dp_ctl_a <= gnt1 ? req1_ctl[0] : req0_ctl[0];
            dp_ctl_b <= gnt1 ? req1_ctl[1] : req0_ctl[1];
            dp_a     <= gnt1 ? req1_a : req0_a;
            dp_b     <= gnt1 ? req1_b : req0_b;
            dp_c     <= gnt1 ? req1_c : req0_c;
        end else begin
            dp_ctl_a <= 1'b0;
            dp_ctl_b <= 1'b0;
            dp_a     <= '0;
            dp_b     <= '0;
            dp_c     <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (flush) begin
                        state_q <= StDrain;
                    end else if (xfer) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (flush) begin
                        state_q <= StDrain;
                    end else if (inflight_d == '0) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    if (inflight_q == '0) begin
                        state_q    <= StIdle;
                        flush_done <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sdp_arb_ctrl.sv
// Directed bench for sdp_arb_ctrl: per-cycle vectors with hand-computed expectations.
// dp_out is driven as 8'h80 + cycle so returned data identifies the response cycle.
module tb_sdp_arb_ctrl;
    localparam logic [25:0] DP0 = {1'b0, 1'b1, 8'h12, 8'h34, 8'h01};
    localparam logic [25:0] DP1 = {1'b1, 1'b0, 8'h56, 8'h78, 8'h9A};

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_ctl, req1_ctl;
    logic [7:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
    logic       dp_ctl_a, dp_ctl_b;
    logic [7:0] dp_a, dp_b, dp_c, dp_out;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp_data;
    logic       flush, flush_done, busy;
    logic [25:0] dp_bus;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    assign dp_bus = {dp_ctl_b, dp_ctl_a, dp_a, dp_b, dp_c};

    always #5 clk = ~clk;

    sdp_arb_ctrl #(.W(8), .LAT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctl   (req0_ctl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctl   (req1_ctl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .dp_ctl_a   (dp_ctl_a),
        .dp_ctl_b   (dp_ctl_b),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_c       (dp_c),
        .dp_out     (dp_out),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle.
    task automatic step(input string tag, input logic rst, input logic v0, input logic v1,
                        input logic fl, input logic er0, input logic er1, input logic es0,
                        input logic es1, input logic eb, input logic efd,
                        input logic [25:0] edp);
        logic [7:0] edata;
        @(posedge clk);
        #1;
        reset      = rst;
        req0_valid = v0;
        req1_valid = v1;
        flush      = fl;
        dp_out     = 8'h80 + 8'(cyc);
        edata      = (es0 || es1) ? 8'h80 + 8'(cyc) : 8'h00;
        #3;
        check_eq($sformatf("%s c%0d ready0", tag, cyc), 32'(req0_ready), 32'(er0));
        check_eq($sformatf("%s c%0d ready1", tag, cyc), 32'(req1_ready), 32'(er1));
        check_eq($sformatf("%s c%0d rsp0", tag, cyc), 32'(rsp0_valid), 32'(es0));
        check_eq($sformatf("%s c%0d rsp1", tag, cyc), 32'(rsp1_valid), 32'(es1));
        check_eq($sformatf("%s c%0d rsp_data", tag, cyc), 32'(rsp_data), 32'(edata));
        check_eq($sformatf("%s c%0d busy", tag, cyc), 32'(busy), 32'(eb));
        check_eq($sformatf("%s c%0d flush_done", tag, cyc), 32'(flush_done), 32'(efd));
        check_eq($sformatf("%s c%0d dp", tag, cyc), 32'(dp_bus), 32'(edp));
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; dp_out = '0;
        req0_ctl = 2'b01; req0_a = 8'h12; req0_b = 8'h34; req0_c = 8'h01;
        req1_ctl = 2'b10; req1_a = 8'h56; req1_b = 8'h78; req1_c = 8'h9A;

        //        tag       rst v0 v1 fl  r0 r1 s0 s1 b  fd dp
        step("por",    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0);
        step("por",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        cyc = 0;
        step("single", 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, '0);
        step("single", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, DP0);
        step("single", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0);
        step("single", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0);
        step("single", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, '0);
        step("single", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        // Last grant was req0, so req1 wins first under contention.
        cyc = 0;
        step("contend", 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, '0);
        step("contend", 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, DP1);
        step("contend", 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, DP0);
        step("contend", 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, DP1);
        step("contend", 1, 1, 1, 0, 0, 1, 0, 1, 1, 0, DP0);
        step("contend", 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, DP1);
        step("contend", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, DP0);
        step("contend", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, '0);
        step("contend", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, '0);
        step("contend", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, '0);
        step("contend", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        cyc = 0;
        step("stream", 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, '0);
        step("stream", 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, DP1);
        step("stream", 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, DP1);
        step("stream", 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, DP1);
        step("stream", 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, DP1);
        step("stream", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, DP1);
        step("stream", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, '0);
        step("stream", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, '0);
        step("stream", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, '0);
        step("stream", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        cyc = 0;
        step("flush", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, '0);
        step("flush", 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, DP0);
        step("flush", 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, DP1);
        step("flush", 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, '0);
        step("flush", 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, '0);
        step("flush", 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, '0);
        step("flush", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, '0);
        step("flush", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
        step("flush", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        cyc = 0;
        step("flush_idle", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, '0);
        step("flush_idle", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        step("flush_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
        step("flush_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

        // Reset lands with two req1 ops in flight; afterwards req0 must win first.
        cyc = 0;
        step("areset", 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, '0);
        step("areset", 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, DP1);
        step("areset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
        step("areset", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            step("areset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        end
        step("areset", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, '0);
        step("areset", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, DP0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
